// File: rtl/psx_pkg.sv
// Shared definitions for the PlayStation pad poller: state encoding,
// the fixed poll command sequence and the response byte that marks a live pad.
package psx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ATT_LOW,
        XFER,
        WAIT_ACK,
        GAP,
        HOLD
    } state_t;

    localparam int         FRAME_BYTES = 5;
    localparam logic [7:0] CMD_START   = 8'h01;
    localparam logic [7:0] CMD_POLL    = 8'h42;
    localparam logic [7:0] CMD_IDLE    = 8'h00;
    localparam logic [7:0] PAD_READY   = 8'h5A;

    // Response bytes kept from a frame until it completes good.
    typedef struct packed {
        logic [7:0] id;
        logic [7:0] lo;
    } frame_cap_t;

    function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return CMD_START;
            3'd1:    return CMD_POLL;
            default: return CMD_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/psx_byte_xfer.sv
// Full-duplex serializer for one pad byte: cmd shifted out on psx_clk falls,
// psx_dat shifted in on rises, both LSB first. done pulses after the last high phase.
module psx_byte_xfer #(
    parameter int CLK_HALF = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       psx_dat,
    output logic       psx_clk,
    output logic       cmd,
    output logic [7:0] rx_byte,
    output logic       done
);
    localparam int            PW      = $clog2(CLK_HALF + 1);
    localparam logic [PW-1:0] PH_LAST = PW'(CLK_HALF - 1);

    logic          busy;
    logic [2:0]    bit_cnt;
    logic [PW-1:0] ph_cnt;
    logic [7:0]    tx_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            bit_cnt <= '0;
            ph_cnt  <= '0;
            tx_sr   <= '0;
            rx_byte <= '0;
            psx_clk <= 1'b1;
            cmd     <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy    <= 1'b1;
                    bit_cnt <= '0;
                    ph_cnt  <= '0;
                    tx_sr   <= {1'b1, tx_byte[7:1]};
                    psx_clk <= 1'b0;
                    cmd     <= tx_byte[0];
                end
            end else if (ph_cnt == PH_LAST) begin
                ph_cnt <= '0;
                if (!psx_clk) begin
                    psx_clk <= 1'b1;
                    rx_byte <= {psx_dat, rx_byte[7:1]};
                end else if (bit_cnt == 3'd7) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    cmd  <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                    psx_clk <= 1'b0;
                    cmd     <= tx_sr[0];
                    tx_sr   <= {1'b1, tx_sr[7:1]};
                end
            end else begin
                ph_cnt <= ph_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/psx_poll_sequencer.sv
// Periodic PlayStation digital pad poller: frames 01/42/00/00/00 under att,
// waits for ACK between bytes and publishes buttons/pad_id on a good frame.
module psx_poll_sequencer
    import psx_pkg::*;
#(
    parameter int CLK_HALF    = 4,
    parameter int ATT_SETUP   = 15,
    parameter int BYTE_GAP    = 8,
    parameter int ACK_TIMEOUT = 200,
    parameter int POLL_PERIOD = 33333
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        psx_dat,
    input  logic        psx_ack,
    output logic        psx_clk,
    output logic        cmd,
    output logic        att,
    output logic [15:0] buttons,
    output logic [7:0]  pad_id,
    output logic        frame_valid,
    output logic        frame_err
);
    localparam logic [31:0] PERIOD    = 32'(POLL_PERIOD);
    localparam logic [2:0]  LAST_BYTE = 3'(FRAME_BYTES - 1);

    state_t     state;
    logic [31:0] period_cnt;
    logic [15:0] wait_cnt;
    logic [2:0]  byte_idx;
    frame_cap_t  cap;
    logic        start;
    logic [7:0]  rx_byte;
    logic        done;

    // Issued one cycle early so psx_clk falls exactly when the wait expires.
    always_comb begin
        start = ((state == ATT_LOW) && (wait_cnt == 16'(ATT_SETUP - 1))) ||
                ((state == GAP)     && (wait_cnt == 16'(BYTE_GAP - 1)));
    end

    psx_byte_xfer #(.CLK_HALF(CLK_HALF)) u_xfer (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .tx_byte (cmd_byte(byte_idx)),
        .psx_dat (psx_dat),
        .psx_clk (psx_clk),
        .cmd     (cmd),
        .rx_byte (rx_byte),
        .done    (done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            period_cnt  <= PERIOD;
            wait_cnt    <= '0;
            byte_idx    <= '0;
            cap         <= '0;
            att         <= 1'b1;
            buttons     <= '0;
            pad_id      <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (period_cnt != '1)
                period_cnt <= period_cnt + 32'd1;

            case (state)
                IDLE: begin
                    if (period_cnt >= PERIOD && enable) begin
                        period_cnt <= '0;
                        state      <= ATT_LOW;
                        att        <= 1'b0;
                        wait_cnt   <= '0;
                        byte_idx   <= '0;
                    end
                end
                ATT_LOW, GAP: begin
                    if (start) state    <= XFER;
                    else       wait_cnt <= wait_cnt + 16'd1;
                end
                XFER: begin
                    if (done) begin
                        wait_cnt <= '0;
                        if (byte_idx == 3'd1) cap.id <= rx_byte;
                        if (byte_idx == 3'd3) cap.lo <= rx_byte;
                        if (byte_idx == LAST_BYTE) begin
                            att         <= 1'b1;
                            frame_valid <= 1'b1;
                            buttons     <= ~{rx_byte, cap.lo};
                            pad_id      <= cap.id;
                            state       <= IDLE;
                        end else if (byte_idx == 3'd2 && rx_byte != PAD_READY) begin
                            att       <= 1'b1;
                            frame_err <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            state <= WAIT_ACK;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (!psx_ack) begin
                        state    <= GAP;
                        wait_cnt <= '0;
                        byte_idx <= byte_idx + 3'd1;
                    end else if (wait_cnt == 16'(ACK_TIMEOUT - 1)) begin
                        att       <= 1'b1;
                        frame_err <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                HOLD: begin
                    if (period_cnt >= PERIOD) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psx_poll_sequencer.sv
// Pad model plus scenario tasks for psx_poll_sequencer; expected frame
// outcomes are queued as each scenario is set up and popped when a pulse appears.
module tb_psx_poll_sequencer;
    localparam int PP = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        psx_dat = 1'b1;
    logic        psx_ack = 1'b1;
    logic        psx_clk, cmd, att, frame_valid, frame_err;
    logic [15:0] buttons;
    logic [7:0]  pad_id;

    always #5 clk = ~clk;

    psx_poll_sequencer #(
        .CLK_HALF(4), .ATT_SETUP(15), .BYTE_GAP(8), .ACK_TIMEOUT(200), .POLL_PERIOD(PP)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .psx_dat(psx_dat), .psx_ack(psx_ack),
        .psx_clk(psx_clk), .cmd(cmd), .att(att), .buttons(buttons), .pad_id(pad_id),
        .frame_valid(frame_valid), .frame_err(frame_err)
    );

    typedef struct {
        bit          is_err;
        logic [7:0]  id;
        logic [15:0] btn;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_pass = 0;

    logic [7:0] resp [0:4];
    bit         ack_give [0:3];
    logic [7:0] cmd_rec [0:4];
    int cyc = 0, bitn = 0, byten = 0, frame_bytes = 0, ack_cnt = 0;
    int lowc = 0, highc = 0, low_min = 99, low_max = 0, high_min = 99, high_max = 0;
    int att_fall_cyc = 0, att_falls = 0;
    logic prev_clk = 1'b1, prev_att = 1'b1;
    bit both_seen = 0;

    // Pad model: data changes on psx_clk falls, ACK pulse ~10 cycles after each byte.
    always @(negedge clk) begin
        cyc++;
        if (frame_valid && frame_err) both_seen = 1;
        if (prev_att && !att) begin
            att_fall_cyc = cyc;
            att_falls++;
            frame_bytes = 0;
        end
        if (att) begin
            bitn = 0; byten = 0; ack_cnt = 0;
            psx_ack = 1'b1; psx_dat = 1'b1;
        end else begin
            if (prev_clk && !psx_clk) begin
                if (bitn != 0) begin
                    if (highc < high_min) high_min = highc;
                    if (highc > high_max) high_max = highc;
                end
                lowc = 1;
                if (byten < 5) begin
                    psx_dat = resp[byten][bitn];
                    cmd_rec[byten][bitn] = cmd;
                end
            end else if (!prev_clk && psx_clk) begin
                if (lowc < low_min) low_min = lowc;
                if (lowc > low_max) low_max = lowc;
                highc = 1;
                bitn++;
                if (bitn == 8) begin
                    bitn = 0;
                    if (byten < 4 && ack_give[byten]) ack_cnt = 12;
                    byten++;
                    frame_bytes = byten;
                end
            end else if (!psx_clk) lowc++;
            else highc++;
            if (ack_cnt > 0) ack_cnt--;
            psx_ack = !(ack_cnt == 1 || ack_cnt == 2);
        end
        prev_clk = psx_clk;
        prev_att = att;
    end

    task automatic wait_outcome(input int budget, output int kind, output int at_cyc);
        kind = 2; at_cyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (frame_valid) begin kind = 0; at_cyc = cyc; break; end
            if (frame_err)   begin kind = 1; at_cyc = cyc; break; end
        end
    endtask

    task automatic wait_att_fall(input int budget, output bit seen);
        int f0;
        f0 = att_falls; seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (att_falls != f0) begin seen = 1; break; end
        end
    endtask

    task automatic check_outcome(input string name, input int kind);
        exp_t e;
        int want;
        e = sb.pop_front();
        want = e.is_err ? 1 : 0;
        n_checks++;
        if (kind !== want) $display("FAIL %s_kind: got %0d want %0d (0 valid,1 err,2 none)", name, kind, want);
        else n_pass++;
        n_checks++;
        if (pad_id !== e.id) $display("FAIL %s_pad_id: got %h want %h", name, pad_id, e.id);
        else n_pass++;
        n_checks++;
        if (buttons !== e.btn) $display("FAIL %s_buttons: got %h want %h", name, buttons, e.btn);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (att !== 1'b1) $display("FAIL reset_att: got %b want 1", att); else n_pass++;
        n_checks++; if (psx_clk !== 1'b1) $display("FAIL reset_psx_clk: got %b want 1", psx_clk); else n_pass++;
        n_checks++; if (cmd !== 1'b1) $display("FAIL reset_cmd: got %b want 1", cmd); else n_pass++;
        n_checks++; if (buttons !== 16'h0) $display("FAIL reset_buttons: got %h want 0000", buttons); else n_pass++;
        n_checks++; if (pad_id !== 8'h0) $display("FAIL reset_pad_id: got %h want 00", pad_id); else n_pass++;
        n_checks++; if ({frame_valid, frame_err} !== 2'b00) $display("FAIL reset_pulses: got %b want 00", {frame_valid, frame_err}); else n_pass++;
    endtask

    task automatic test_good_frame();
        exp_t e;
        int kind, at;
        low_min = 99; low_max = 0; high_min = 99; high_max = 0;
        e.is_err = 0; e.id = 8'h73; e.btn = 16'h0001; sb.push_back(e);
        enable = 1'b1; rst = 1'b0;
        wait_outcome(3000, kind, at);
        check_outcome("good", kind);
        enable = 1'b0;
        n_checks++; if (cmd_rec[0] !== 8'h01) $display("FAIL cmd_byte0: got %h want 01", cmd_rec[0]); else n_pass++;
        n_checks++; if (cmd_rec[1] !== 8'h42) $display("FAIL cmd_byte1: got %h want 42", cmd_rec[1]); else n_pass++;
        n_checks++; if (cmd_rec[3] !== 8'h00) $display("FAIL cmd_byte3: got %h want 00", cmd_rec[3]); else n_pass++;
        n_checks++; if (frame_bytes !== 5) $display("FAIL good_bytes: got %0d want 5", frame_bytes); else n_pass++;
        n_checks++;
        if (low_min !== 4 || low_max !== 4) $display("FAIL low_phase: got %0d..%0d want 4", low_min, low_max);
        else n_pass++;
        n_checks++;
        if (high_min !== 4 || high_max !== 4) $display("FAIL high_phase: got %0d..%0d want 4", high_min, high_max);
        else n_pass++;
    endtask

    task automatic test_ack_timeout();
        exp_t e;
        int kind, at, t0;
        bit seen;
        ack_give[0] = 0;
        e.is_err = 1; e.id = 8'h73; e.btn = 16'h0001; sb.push_back(e);
        enable = 1'b1;
        wait_att_fall(2 * PP, seen);
        n_checks++; if (seen !== 1'b1) $display("FAIL timeout_start: got %b want 1", seen); else n_pass++;
        t0 = att_fall_cyc;
        wait_outcome(1000, kind, at);
        check_outcome("timeout", kind);
        n_checks++;
        if (at - t0 < 278 || at - t0 > 280) $display("FAIL timeout_latency: got %0d want 278..280", at - t0);
        else n_pass++;
        n_checks++; if (att !== 1'b1) $display("FAIL timeout_att: got %b want 1", att); else n_pass++;
        n_checks++; if (frame_bytes !== 1) $display("FAIL timeout_bytes: got %0d want 1", frame_bytes); else n_pass++;
        enable = 1'b0;
        ack_give[0] = 1;
    endtask

    task automatic test_bad_id();
        exp_t e;
        int kind, at, t0;
        bit seen;
        resp[2] = 8'h41;
        e.is_err = 1; e.id = 8'h73; e.btn = 16'h0001; sb.push_back(e);
        enable = 1'b1;
        wait_att_fall(2 * PP, seen);
        t0 = att_fall_cyc;
        wait_outcome(1000, kind, at);
        check_outcome("bad_id", kind);
        n_checks++; if (frame_bytes !== 3) $display("FAIL bad_id_bytes: got %0d want 3", frame_bytes); else n_pass++;
        n_checks++;
        if ({att, psx_clk, cmd} !== 3'b111) $display("FAIL bad_id_lines: got %b want 111", {att, psx_clk, cmd});
        else n_pass++;
        resp[2] = 8'h5A;
        e.is_err = 0; e.id = 8'h73; e.btn = 16'h0001; sb.push_back(e);
        wait_att_fall(2 * PP, seen);
        n_checks++;
        if (!seen || att_fall_cyc - t0 < PP || att_fall_cyc - t0 > PP + 2)
            $display("FAIL bad_id_restart: got %0d want %0d..%0d", att_fall_cyc - t0, PP, PP + 2);
        else n_pass++;
        wait_outcome(3000, kind, at);
        check_outcome("after_bad_id", kind);
        enable = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int kind, at;
        bit seen;
        enable = 1'b1;
        wait_att_fall(2 * PP, seen);
        for (int i = 0; i < 1000; i++) begin
            if (frame_bytes == 1 && bitn >= 3) break;
            @(negedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if ({att, psx_clk, cmd} !== 3'b111) $display("FAIL rst_mid_lines: got %b want 111", {att, psx_clk, cmd});
        else n_pass++;
        n_checks++; if (pad_id !== 8'h0) $display("FAIL rst_mid_pad_id: got %h want 00", pad_id); else n_pass++;
        rst = 1'b0;
        e.is_err = 0; e.id = 8'h73; e.btn = 16'h0001; sb.push_back(e);
        wait_outcome(3000, kind, at);
        check_outcome("rst_mid", kind);
    endtask

    task automatic test_enable_drop();
        exp_t e;
        int kind, at, f0;
        bit seen;
        enable = 1'b1;
        wait_att_fall(2 * PP, seen);
        for (int i = 0; i < 1000; i++) begin
            if (frame_bytes == 3) break;
            @(negedge clk); #1;
        end
        enable = 1'b0;
        resp[3] = 8'h5F; resp[4] = 8'hF7;
        e.is_err = 0; e.id = 8'h73; e.btn = 16'h08A0; sb.push_back(e);
        wait_outcome(3000, kind, at);
        check_outcome("en_drop", kind);
        f0 = att_falls;
        repeat (2 * PP + 100) @(negedge clk);
        #1;
        n_checks++; if (att_falls !== f0) $display("FAIL en_drop_idle: got %0d falls want 0", att_falls - f0); else n_pass++;
    endtask

    task automatic test_exclusive();
        n_checks++; if (both_seen !== 1'b0) $display("FAIL pulse_exclusive: got %b want 0", both_seen); else n_pass++;
        n_checks++; if (sb.size() !== 0) $display("FAIL scoreboard_left: got %0d want 0", sb.size()); else n_pass++;
    endtask

    initial begin
        resp[0] = 8'hFF; resp[1] = 8'h73; resp[2] = 8'h5A; resp[3] = 8'hFE; resp[4] = 8'hFF;
        for (int i = 0; i < 4; i++) ack_give[i] = 1;
        for (int i = 0; i < 5; i++) cmd_rec[i] = 8'hxx;
        test_reset();
        test_good_frame();
        test_ack_timeout();
        test_bad_id();
        test_reset_mid();
        test_enable_drop();
        test_exclusive();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
